// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Definitions shared by the digital-clock blocks:
//   - state_t      : state encoding for the keypad hour-entry FSM
//   - HOUR_MAX_24  : highest legal 24h hour (packed BCD)
//   - HOUR_MAX_12  : highest legal 12h hour (packed BCD)
//   - NIBBLE_BLANK : echo nibble for a digit that has not been typed yet
//   - is_bcd()     : true when a nibble holds a decimal digit 0..9
// ----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TENS = 3'd1,
        ST_ONES = 3'd2,
        ST_APM  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] HOUR_MAX_24  = 8'h23;
    localparam logic [7:0] HOUR_MAX_12  = 8'h12;
    localparam logic [3:0] NIBBLE_BLANK = 4'hF;
    localparam logic [7:0] ECHO_BLANK   = {NIBBLE_BLANK, NIBBLE_BLANK};

    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_hour_12to24.sv
// ----------------------------------------------------------------------------
// bcd_hour_12to24
// Pure combinational validation and conversion of a two-digit BCD hour into a
// packed-BCD 24h hour. Reusable by any block that takes an hour from a keypad
// (hour entry, alarm set).
//
// Ports:
//   tens   in  4  tens digit (BCD, may be out of range)
//   ones   in  4  ones digit (BCD, may be out of range)
//   pm     in  1  1 = PM, 0 = AM (only meaningful when mode = 0)
//   mode   in  1  0 = 12h value, 1 = 24h value
//   hour24 out 8  converted hour 8'h00..8'h23 (don't-care when valid = 0)
//   valid  out 1  digits are BCD and the hour is legal for the mode
// ----------------------------------------------------------------------------
module bcd_hour_12to24
    import clock_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       pm,
    input  logic       mode,
    output logic [7:0] hour24,
    output logic       valid
);

    logic [7:0] raw;
    assign raw = {tens, ones};

    // With both nibbles known to be 0..9, packed BCD orders exactly like the
    // decimal value, so range checks compare packed values directly.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        hour24 = 8'h00;
        valid  = 1'b0;
        if (is_bcd(tens) && is_bcd(ones)) begin
            if (mode) begin
                valid  = (raw <= HOUR_MAX_24);
                hour24 = raw;
            end else begin
                valid = (raw != 8'h00) && (raw <= HOUR_MAX_12);
                if (raw == HOUR_MAX_12) begin
                    // 12 AM is midnight, 12 PM is noon.
                    hour24 = pm ? HOUR_MAX_12 : 8'h00;
                end else if (!pm) begin
                    hour24 = raw;
                end else if (tens == 4'd0 && ones <= 4'd7) begin
                    // 01..07 PM -> 13..19: ones + 2 stays a single digit.
                    hour24 = {4'd1, ones + 4'd2};
                end else if (tens == 4'd0) begin
                    // 08, 09 PM -> 20, 21: ones + 12 carries into the tens.
                    hour24 = {4'd2, ones - 4'd8};
                end else begin
                    // 10, 11 PM -> 22, 23.
                    hour24 = {4'd2, ones + 4'd2};
                end
            end
        end
    end

endmodule

// File: rtl/hour_entry_12to24.sv
// ----------------------------------------------------------------------------
// hour_entry_12to24
// Keypad-side hour entry for the digital clock. Collects two BCD digits (and
// an AM/PM key in 12h mode), validates them and loads a packed-BCD 24h hour
// into the hour counter with a one-cycle Load pulse.
//
// Ports:
//   clk        in  1  system clock
//   rst_n      in  1  synchronous reset, active-low
//   Mode       in  1  0 = 12h entry, 1 = 24h entry; sampled at Start
//   Start      in  1  pulse; begin an entry
//   Cancel     in  1  pulse; abort entry
//   DigitValid in  1  pulse; Digit is valid this cycle
//   Digit      in  4  BCD digit from keypad
//   ApmValid   in  1  pulse; AM/PM key pressed
//   ApmPm      in  1  1 = PM, 0 = AM; qualified by ApmValid
//   HourOut    out 8  packed-BCD 24h hour; holds last committed value
//   Load       out 1  one-cycle pulse; HourOut is newly valid
//   Error      out 1  one-cycle pulse; entry rejected
//   Busy       out 1  high in any state except IDLE
//   EchoHour   out 8  digits typed so far; untyped nibble reads 4'hF
//   EchoPm     out 1  PM indicator during entry
//
// Optional build macro HOUR_ENTRY_TIMEOUT_EN: abort an entry with an Error
// pulse after TIMEOUT_CYCLES cycles without an accepted input. Without the
// macro no counter exists and an entry waits indefinitely.
// ----------------------------------------------------------------------------
module hour_entry_12to24
    import clock_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Mode,
    input  logic       Start,
    input  logic       Cancel,
    input  logic       DigitValid,
    input  logic [3:0] Digit,
    input  logic       ApmValid,
    input  logic       ApmPm,
    output logic [7:0] HourOut,
    output logic       Load,
    output logic       Error,
    output logic       Busy,
    output logic [7:0] EchoHour,
    output logic       EchoPm
);

    state_t     state;
    logic       mode_q;     // 1 = 24h, latched at Start
    logic [3:0] tens_q;
    logic [3:0] ones_q;

    logic [7:0] conv_hour;
    logic       conv_valid;

    bcd_hour_12to24 u_conv (
        .tens   (tens_q),
        .ones   (ones_q),
        .pm     (EchoPm),
        .mode   (mode_q),
        .hour24 (conv_hour),
        .valid  (conv_valid)
    );

    assign Busy = (state != ST_IDLE);

`ifdef HOUR_ENTRY_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        in_entry;
    logic        accepted;
    logic        timed_out;

    assign in_entry  = (state == ST_TENS) || (state == ST_ONES) || (state == ST_APM);
    assign accepted  = (((state == ST_TENS) || (state == ST_ONES)) && DigitValid)
                     || ((state == ST_APM) && ApmValid);
    assign timed_out = in_entry && !accepted && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

    // Counts consecutive entry-state cycles with no accepted key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= 32'd0;
        end else if (!in_entry || accepted) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= 1'b1;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            HourOut  <= 8'h00;
            Load     <= 1'b0;
            Error    <= 1'b0;
            EchoHour <= ECHO_BLANK;
            EchoPm   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; defaults below make Load and
            // Error single-cycle pulses.
            Load  <= 1'b0;
            Error <= 1'b0;
            if (state != ST_IDLE && Cancel) begin
                state    <= ST_IDLE;
                EchoHour <= ECHO_BLANK;
`ifdef HOUR_ENTRY_TIMEOUT_EN
            end else if (timed_out) begin
                state    <= ST_IDLE;
                Error    <= 1'b1;
                EchoHour <= ECHO_BLANK;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Start) begin
                            state    <= ST_TENS;
                            mode_q   <= Mode;
                            EchoHour <= ECHO_BLANK;
                            EchoPm   <= 1'b0;
                        end
                    end
                    ST_TENS: begin
                        if (DigitValid) begin
                            tens_q        <= Digit;
                            EchoHour[7:4] <= Digit;
                            state         <= ST_ONES;
                        end
                    end
                    ST_ONES: begin
                        if (DigitValid) begin
                            ones_q        <= Digit;
                            EchoHour[3:0] <= Digit;
                            state         <= mode_q ? ST_DONE : ST_APM;
                        end
                    end
                    ST_APM: begin
                        // A digit key here is ignored, even alongside AM/PM.
                        if (ApmValid) begin
                            EchoPm <= ApmPm;
                            state  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (conv_valid) begin
                            HourOut <= conv_hour;
                            Load    <= 1'b1;
                        end else begin
                            Error   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hour_entry_12to24.sv
// ----------------------------------------------------------------------------
// tb_hour_entry_12to24
// Self-checking bench for hour_entry_12to24. Each completed entry pushes its
// expected outcome (Load or Error, HourOut, clock edge of the pulse) onto a
// scoreboard queue; a monitor pops and compares whenever Load or Error fires.
// ----------------------------------------------------------------------------
module tb_hour_entry_12to24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Mode;
    logic       Start;
    logic       Cancel;
    logic       DigitValid;
    logic [3:0] Digit;
    logic       ApmValid;
    logic       ApmPm;
    logic [7:0] HourOut;
    logic       Load;
    logic       Error;
    logic       Busy;
    logic [7:0] EchoHour;
    logic       EchoPm;

    hour_entry_12to24 #(.TIMEOUT_CYCLES(32'd10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Mode       (Mode),
        .Start      (Start),
        .Cancel     (Cancel),
        .DigitValid (DigitValid),
        .Digit      (Digit),
        .ApmValid   (ApmValid),
        .ApmPm      (ApmPm),
        .HourOut    (HourOut),
        .Load       (Load),
        .Error      (Error),
        .Busy       (Busy),
        .EchoHour   (EchoHour),
        .EchoPm     (EchoPm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_passed = 0;

    typedef struct {
        logic       load;
        logic [7:0] hour;
        int         edge_no;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_hour = 8'h00;
    int         last_edge  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_passed++;
    endtask

    // One-cycle pulse on the selected inputs, driven at the falling edge.
    task automatic drive(input logic s, input logic c, input logic dv,
                         input logic [3:0] d, input logic av, input logic ap);
        @(negedge clk);
        Start = s; Cancel = c; DigitValid = dv; Digit = d; ApmValid = av; ApmPm = ap;
        @(posedge clk);
        #1;
        last_edge = cyc;
        Start = 0; Cancel = 0; DigitValid = 0; ApmValid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model in plain decimal arithmetic; pushes the expected result
    // of an entry whose last accepted key landed on last_edge.
    task automatic expect_entry(input logic m24, input logic [3:0] t,
                                input logic [3:0] o, input logic pm);
        int   v, h;
        logic ok;
        exp_t e;
        ok = 1'b0;
        h  = 0;
        if (t <= 9 && o <= 9) begin
            v = int'(t) * 10 + int'(o);
            if (m24) begin
                ok = (v <= 23);
                h  = v;
            end else begin
                ok = (v >= 1 && v <= 12);
                if (pm) h = (v == 12) ? 12 : v + 12;
                else    h = (v == 12) ? 0 : v;
            end
        end
        if (ok) model_hour = 8'((h / 10) * 16 + (h % 10));
        e.load    = ok;
        e.hour    = model_hour;
        e.edge_no = last_edge + 1;
        sb.push_back(e);
    endtask

    task automatic entry12(input logic [3:0] t, input logic [3:0] o, input logic pm);
        Mode = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, t, 0, 0);
        drive(0, 0, 1, o, 0, 0);
        drive(0, 0, 0, 0, 1, pm);
        expect_entry(1'b0, t, o, pm);
        idle(3);
    endtask

    task automatic entry24(input logic [3:0] t, input logic [3:0] o);
        Mode = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, t, 0, 0);
        drive(0, 0, 1, o, 0, 0);
        expect_entry(1'b1, t, o, 1'b0);
        idle(3);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (Load === 1'b1 || Error === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, Load, Error}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("load", Load, e.load);
                check("error", Error, !e.load);
                check("hour_out", HourOut, e.hour);
                check("latency", cyc, e.edge_no);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; Mode = 0; Start = 0; Cancel = 0; DigitValid = 0;
        Digit = 0; ApmValid = 0; ApmPm = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hour", HourOut, 8'h00);
        check("rst_load", Load, 1'b0);
        check("rst_error", Error, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_echo", EchoHour, 8'hFF);
        check("rst_echo_pm", EchoPm, 1'b0);
        @(negedge clk);
        rst_n = 1;

        // 12h 07 PM with echo checks along the way.
        Mode = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        check("busy_after_start", Busy, 1'b1);
        drive(0, 0, 1, 4'd0, 0, 0);
        check("echo_tens", EchoHour, 8'h0F);
        drive(0, 0, 1, 4'd7, 0, 0);
        check("echo_both", EchoHour, 8'h07);
        drive(0, 0, 0, 0, 1, 1);
        check("echo_pm", EchoPm, 1'b1);
        expect_entry(1'b0, 4'd0, 4'd7, 1'b1);
        idle(3);
        check("idle_after_done", Busy, 1'b0);

        // 12h boundaries.
        entry12(4'd1, 4'd2, 1'b0);
        entry12(4'd1, 4'd2, 1'b1);
        entry12(4'd1, 4'd1, 1'b1);
        entry12(4'd0, 4'd0, 1'b0);
        entry12(4'd0, 4'd9, 1'b1);
        entry12(4'd1, 4'd3, 1'b0);

        // 24h entries.
        entry24(4'd2, 4'd3);
        entry24(4'd2, 4'd4);
        entry24(4'd1, 4'hA);
        entry24(4'd0, 4'd9);

        // 12h entry with ignored keys: Start + Mode change while busy,
        // stray digit in APM, then digit and AM/PM together.
        Mode = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        Mode = 1'b1;
        drive(0, 0, 1, 4'd0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd8, 0, 0);
        drive(0, 0, 1, 4'd5, 0, 0);
        check("apm_digit_ignored", EchoHour, 8'h08);
        drive(0, 0, 1, 4'd3, 1, 1);
        expect_entry(1'b0, 4'd0, 4'd8, 1'b1);
        idle(3);

        // Cancel after the tens digit.
        Mode = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd1, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("cancel_busy", Busy, 1'b0);
        check("cancel_echo", EchoHour, 8'hFF);
        idle(3);

        // Cancel together with a digit: cancel wins.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 4'd2, 0, 0);
        check("cancel_dv_busy", Busy, 1'b0);
        check("cancel_dv_echo", EchoHour, 8'hFF);
        idle(3);

        // Reset mid-entry (in ONES).
        Mode = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd1, 0, 0);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1;
        model_hour = 8'h00;
        check("midrst_hour", HourOut, 8'h00);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_echo", EchoHour, 8'hFF);
        check("midrst_echo_pm", EchoPm, 1'b0);
        check("midrst_load_err", {30'd0, Load, Error}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        entry24(4'd1, 4'd5);

        // Idle entry: timeout build aborts, default build keeps waiting.
        Mode = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
`ifdef HOUR_ENTRY_TIMEOUT_EN
        begin
            exp_t e;
            e.load    = 1'b0;
            e.hour    = model_hour;
            e.edge_no = last_edge + 10;
            sb.push_back(e);
        end
        idle(15);
        check("timeout_busy", Busy, 1'b0);
        check("timeout_echo", EchoHour, 8'hFF);
`else
        idle(1000);
        check("no_timeout_busy", Busy, 1'b1);
        drive(0, 1, 0, 0, 0, 0);
        check("no_timeout_cancel", Busy, 1'b0);
`endif
        idle(3);

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/hour_entry_12to24.md
Name: hour_entry_12to24

Overview:
- Keypad-side hour entry for the digital clock; inverse of the 24h-to-12h display conversion.
- Accepts two BCD digits, plus an AM/PM key in 12h mode, validates them, and converts to a packed-BCD 24h hour.
- Issues a one-cycle Load pulse toward the hour counter.
- Sits between the debounced keypad decoder and the time-keeping counters.

Parameters:
- TIMEOUT_CYCLES, 32'd500_000_000, idle cycles in an entry state before abort (used only with TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- Mode  in  1  0 = 12h entry, 1 = 24h entry; sampled at Start
- Start  in  1  pulse; begin an entry
- Cancel  in  1  pulse; abort entry
- DigitValid  in  1  pulse; Digit is valid this cycle
- Digit  in  4  BCD digit from keypad
- ApmValid  in  1  pulse; AM/PM key pressed
- ApmPm  in  1  1 = PM, 0 = AM; qualified by ApmValid
- HourOut  out  8  packed-BCD 24h hour, 8'h00..8'h23; holds last committed value
- Load  out  1  one-cycle pulse; HourOut is newly valid
- Error  out  1  one-cycle pulse; entry rejected
- Busy  out  1  high in any state except IDLE
- EchoHour  out  8  digits typed so far, for display; unentered nibble reads 4'hF
- EchoPm  out  1  PM indicator during entry

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; HourOut=8'h00; Load=0; Error=0; Busy=0; EchoHour=8'hFF; EchoPm=0; latched mode=1.
- States: IDLE, TENS, ONES, APM, DONE.
- IDLE:
  - Start -> TENS; latch Mode; EchoHour=8'hFF; EchoPm=0.
  - All other inputs ignored.
- TENS:
  - DigitValid -> store tens digit; EchoHour[7:4]=Digit; go to ONES.
- ONES:
  - DigitValid -> store ones digit; EchoHour[3:0]=Digit.
  - Latched 24h mode -> DONE.
  - Latched 12h mode -> APM.
- APM:
  - ApmValid -> EchoPm=ApmPm; go to DONE.
  - DigitValid is ignored in this state.
- DONE (one cycle): validate and convert, then return to IDLE.
  - Valid: Load=1 and HourOut updated in the same cycle.
  - Invalid: Error=1 and HourOut unchanged.
  - Latency: Load/Error appear exactly 2 clk edges after the final accepted input pulse.
- Validation:
  - Any digit > 9 -> invalid.
  - 24h mode: value must be 00..23.
  - 12h mode: value must be 01..12.
- 12h -> 24h conversion, BCD-correct (no binary add on packed BCD):
  - 12 AM -> 8'h00.
  - 01..11 AM -> unchanged.
  - 12 PM -> 8'h12.
  - 01..07 PM -> 8'h13..8'h19.
  - 08 PM -> 8'h20, 09 PM -> 8'h21, 10 PM -> 8'h22, 11 PM -> 8'h23.
- 24h mode: HourOut = {tens, ones}.
- Cancel in any non-IDLE state -> IDLE next cycle; no Load, no Error; EchoHour=8'hFF.
- Simultaneous events:
  - Cancel beats every other input.
  - DigitValid and ApmValid together in APM: accept ApmValid only.
  - Start while Busy is ignored.
- A Mode change after Start has no effect on the entry in progress.

Optional Feature:
- Macro HOUR_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter reloads on every accepted input and counts in TENS/ONES/APM.
  - After TIMEOUT_CYCLES idle cycles: Error pulse, go to IDLE, EchoHour=8'hFF.
  - Cancel takes priority over timeout.
- Not defined: no counter is built; an entry waits indefinitely.

Decomposition:
- Shared package clock_pkg holds:
  - State encoding typedef.
  - Constants HOUR_MAX_24=8'h23, HOUR_MAX_12=8'h12, NIBBLE_BLANK=4'hF.
- One sub-module, bcd_hour_12to24: pure combinational {tens, ones, pm, mode} -> {hour24, valid}, instantiated in DONE logic.
  - Reusable by any future alarm-set block.

Test Plan:
- 12h entry: Start(Mode=0), digits 0,7, ApmValid PM -> Load pulse 2 edges later, HourOut=8'h19.
- 12h boundaries: "12"+AM -> HourOut=8'h00; "12"+PM -> 8'h12; "11"+PM -> 8'h23; "00"+AM -> Error, HourOut unchanged.
- 24h entry: Start(Mode=1), digits 2,3 -> HourOut=8'h23 with no APM state. Digits 2,4 -> Error. Digit 4'hA as ones -> Error.
- Cancel after the tens digit -> Busy drops next cycle, no Load, no Error, EchoHour=8'hFF. Cancel together with DigitValid -> cancel wins.
- Reset mid-entry (rst_n low while in ONES) -> all outputs at reset values next edge. A subsequent full entry works normally.
- With HOUR_ENTRY_TIMEOUT_EN (TIMEOUT_CYCLES=10): Start, no input for 10 cycles -> Error pulse and IDLE. Without the macro -> still Busy after 1000 cycles.
